svi_lane_sampler: RTL and testbench



---
 rtl/svi_lane_sampler_if.sv | 6 +
 rtl/svi_lane_sampler.sv | 110 +++++++++++
 tb/tb_svi_lane_sampler.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/svi_lane_sampler_if.sv
// SVI lane: a single resolved net that a producer may release to z.
// The consumer only ever observes it through modport P.
interface I;
  wire z;
  modport P (input z);
endinterface

// File: rtl/svi_lane_sampler.sv
// Samples an array of SVI lanes every clock, flags persistently floating lanes,
// and hands out snapshots of the last known lane values over valid/ready.
module svi_lane_sampler #(
  parameter int N_LANES    = 8,
  parameter int FLOAT_HOLD = 4,
  parameter int CNT_W      = 8
)(
  input  logic               i_clk,
  input  logic               i_rst,
  I.P                        u_I [N_LANES-1:0],
  input  logic               i_sample_en,
  output logic [N_LANES-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [N_LANES-1:0] o_float,
  output logic               o_all_float,
  output logic [CNT_W-1:0]   o_float_cnt
);

  localparam int RUN_W = $clog2(FLOAT_HOLD + 1);
  localparam int POP_W = $clog2(N_LANES + 1);
  localparam int SUM_W = CNT_W + $clog2(N_LANES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HOLD} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_LANES-1:0] w_unk;
  logic [N_LANES-1:0] w_bit;
  logic [N_LANES-1:0] r_last;
  logic [RUN_W-1:0]   r_run [N_LANES];
  logic [N_LANES-1:0] w_float_nxt;
  logic [N_LANES-1:0] w_rise;
  logic [N_LANES-1:0] r_float;
  logic [N_LANES-1:0] r_data;
  logic [CNT_W-1:0]   r_cnt;
  logic [POP_W-1:0]   w_rise_cnt;

  function automatic logic [RUN_W-1:0] sat_run_inc(input logic [RUN_W-1:0] v);
    if (v >= RUN_W'(FLOAT_HOLD)) return RUN_W'(FLOAT_HOLD);
    return v + RUN_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt_add(input logic [CNT_W-1:0] base,
                                                   input logic [POP_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + SUM_W'(inc);
    if (sum > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return sum[CNT_W-1:0];
  endfunction

  // Lane classification: a z or x sample is unknown; only 0/1 are trusted.
  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    assign w_unk[gi]       = (u_I[gi].z === 1'bz) || $isunknown(u_I[gi].z);
    assign w_bit[gi]       = u_I[gi].z;
    assign w_float_nxt[gi] = (r_run[gi] == RUN_W'(FLOAT_HOLD));
  end

  assign w_rise = w_float_nxt & ~r_float;

  always_comb begin
    w_rise_cnt = '0;
    for (int i = 0; i < N_LANES; i++) w_rise_cnt = w_rise_cnt + POP_W'(w_rise[i]);
  end

  // Float tracking: free-running, independent of the snapshot handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last  <= '0;
      r_float <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < N_LANES; i++) r_run[i] <= '0;
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        r_run[i] <= w_unk[i] ? sat_run_inc(r_run[i]) : '0;
        if (!w_unk[i]) r_last[i] <= w_bit[i];
      end
      r_float <= w_float_nxt;
      r_cnt   <= sat_cnt_add(r_cnt, w_rise_cnt);
    end
  end

  // Snapshot handshake
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_sample_en) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_HOLD;
      S_HOLD:    if (i_ready) w_state_nxt = i_sample_en ? S_CAPTURE : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CAPTURE) r_data <= r_last;
    end
  end

  assign o_data      = r_data;
  assign o_valid     = (r_state == S_HOLD);
  assign o_float     = r_float;
  assign o_all_float = &r_float;
  assign o_float_cnt = r_cnt;

endmodule

// File: tb/tb_svi_lane_sampler.sv
// Bench for svi_lane_sampler: directed scenarios plus randomized traffic,
// scored against a streak/queue based reference model.
module tb_svi_lane_sampler;

  localparam int NL = 8;
  localparam int FH = 4;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          sample_en = 1'b0;
  logic          ready = 1'b0;
  logic [NL-1:0] lane_a = '0;
  logic [NL-1:0] lane_en = '0;
  logic [NL-1:0] o_data, o_float;
  logic          o_valid, o_all_float;
  logic [CW-1:0] o_float_cnt;

  I u_lane [NL-1:0] ();
  for (genvar g = 0; g < NL; g++) begin : g_drv
    assign u_lane[g].z = lane_en[g] ? 1'bz : lane_a[g];
  end

  svi_lane_sampler #(.N_LANES(NL), .FLOAT_HOLD(FH), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .u_I(u_lane), .i_sample_en(sample_en),
    .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
    .o_float(o_float), .o_all_float(o_all_float), .o_float_cnt(o_float_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: lane streaks, last known values, outstanding snapshot queue.
  int            streak [NL];
  logic [NL-1:0] mflag = '0;
  logic [NL-1:0] mlast = '0;
  int            mcnt = 0;
  bit            cap_pend = 0;
  bit            outst = 0;
  logic [NL-1:0] exp_q [$];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) streak[i] = 0;
      mflag = '0; mlast = '0; mcnt = 0; cap_pend = 0; outst = 0;
      exp_q.delete();
    end else begin
      int rises;
      if (cap_pend) begin
        exp_q.push_back(mlast);
        cap_pend = 0;
        outst = 1;
      end else if (outst) begin
        if (ready) begin
          outst = 0;
          cap_pend = sample_en;
        end
      end else begin
        cap_pend = sample_en;
      end
      rises = 0;
      for (int i = 0; i < NL; i++) begin
        if (streak[i] >= FH && !mflag[i]) rises++;
        mflag[i] = (streak[i] >= FH);
        if (lane_en[i]) streak[i]++;
        else begin
          streak[i] = 0;
          mlast[i] = lane_a[i];
        end
      end
      mcnt = (mcnt + rises > CNT_MAX) ? CNT_MAX : mcnt + rises;
    end
  end

  // Monitor: compares live outputs every cycle, pops a snapshot per new transaction.
  bit            mon_on = 0;
  bit            in_txn = 0;
  logic [NL-1:0] cur_exp = '0;

  always @(negedge clk) begin
    if (mon_on) begin
      chk("valid", 32'(o_valid), 32'(outst));
      chk("float", 32'(o_float), 32'(mflag));
      chk("all_float", 32'(o_all_float), 32'(&mflag));
      chk("float_cnt", 32'(o_float_cnt), 32'(mcnt));
      if (o_valid) begin
        if (!in_txn) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL snapshot: got data %0h with no snapshot expected at %0t", o_data, $time);
          end else begin
            cur_exp = exp_q.pop_front();
          end
          in_txn = 1;
        end
        chk("data", 32'(o_data), 32'(cur_exp));
        if (ready) in_txn = 0;
      end
      if (rst) in_txn = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (o_valid !== 1'b1 && k < 10) begin
      step(1);
      k++;
    end
    chk(nm, 32'(o_valid), 32'd1);
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    mon_on = 1;

    // T1: reset while a snapshot is held
    lane_a = 8'hA5; sample_en = 1'b1; ready = 1'b0;
    wait_valid("t1_valid_timeout");
    step(2);
    rst = 1'b1;
    step(1);
    chk("t1_valid", 32'(o_valid), 32'd0);
    chk("t1_data", 32'(o_data), 32'd0);
    chk("t1_float", 32'(o_float), 32'd0);
    chk("t1_cnt", 32'(o_float_cnt), 32'd0);
    rst = 1'b0;

    // T2: streaming snapshots
    lane_a = 8'h3C; sample_en = 1'b1; ready = 1'b1;
    wait_valid("t2_valid_timeout");
    chk("t2_data", 32'(o_data), 32'h3C);
    step(8);

    // T3: backpressure while lanes change
    ready = 1'b0; lane_a = 8'hFF;
    step(5);
    chk("t3_valid", 32'(o_valid), 32'd1);
    chk("t3_data", 32'(o_data), 32'h3C);
    ready = 1'b1;
    step(6);

    // T4: all lanes float for 6 cycles
    lane_a = 8'h55;
    step(4);
    lane_en = 8'hFF;
    step(6);
    chk("t4_float", 32'(o_float), 32'hFF);
    chk("t4_all_float", 32'(o_all_float), 32'd1);
    chk("t4_cnt", 32'(o_float_cnt), 32'd8);

    // T5: release to all-ones
    lane_en = 8'h00; lane_a = 8'hFF;
    step(2);
    chk("t5_float", 32'(o_float), 32'd0);
    chk("t5_cnt", 32'(o_float_cnt), 32'd8);
    step(6);

    // T6: repeated float events saturate the counter
    for (int r = 0; r < 3; r++) begin
      lane_en = 8'hFF;
      step(FH + 1);
      lane_en = 8'h00;
      step(2);
    end
    chk("t6_cnt", 32'(o_float_cnt), CNT_MAX);

    // Randomized traffic with sticky float patterns and occasional reset
    for (int c = 0; c < 400; c++) begin
      lane_a    = NL'($urandom);
      if ($urandom_range(0, 7) == 0) lane_en = NL'($urandom);
      sample_en = ($urandom_range(0, 3) != 0);
      ready     = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst = 1'b0;

    // Drain: every captured snapshot must have been presented
    sample_en = 1'b0; ready = 1'b1; lane_en = '0;
    step(10);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
